ctrlport_gain_regs: RTL
=======================

CTRLPORT_GAIN_REGS -- requirements
Module: ctrlport_gain_regs

Interface
REQ-001 Parameter BASE_ADDR, default 20'h0: byte address of register 0; SHALL be 32-byte aligned.
REQ-002 Parameter RESP_LATENCY, default 1: cycles from request to resp_ack; legal range 1..4.
REQ-003 Parameter COMPAT_NUM, default 32'h0001_0000: value of the read-only COMPAT register.
REQ-004 The block has one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- ctrlport_clk  in  1  sole clock
- ctrlport_rst_n  in  1  async active-low reset
- s_ctrlport_req_wr  in  1  write strobe, one cycle
- s_ctrlport_req_rd  in  1  read strobe, one cycle
- s_ctrlport_req_addr  in  20  byte address
- s_ctrlport_req_data  in  32  write data
- s_ctrlport_resp_ack  out  1  response strobe, one cycle
- s_ctrlport_resp_data  out  32  read data, valid with ack
- gain  out  16  GAIN register value
- enable  out  1  CTRL[0]

Function
REQ-006 Decode SHALL use addr[19:5]==BASE_ADDR[19:5] and offset addr[4:2]; addr[1:0] ignored.
REQ-007 Map: 0x00 COMPAT RO; 0x04 SCRATCH RW 32b; 0x08 GAIN RW [15:0]; 0x0C CTRL RW [0]; 0x10 WR_COUNT RO; 0x14 ERR_COUNT RO; 0x18/0x1C reserved.
REQ-008 Unused bits of RW registers SHALL read 0; writes to RO/reserved offsets SHALL be ignored but acked.
REQ-009 Requests outside the base window SHALL be ignored entirely: no ack, no state change.
REQ-010 FSM states IDLE and BUSY; IDLE->BUSY on a decoded request, BUSY->IDLE in the cycle resp_ack is asserted.
REQ-011 resp_ack SHALL assert for exactly one cycle, RESP_LATENCY cycles after the request cycle.
REQ-012 Write data SHALL take effect in register and gain/enable outputs in the cycle after the request, independent of RESP_LATENCY.
REQ-013 Read data SHALL be sampled in the request cycle and held until ack; resp_data SHALL be 0 when ack is low.
REQ-014 Simultaneous wr and rd: write performed, ack data equals pre-write value, single ack, ERR_COUNT incremented.
REQ-015 A decoded request arriving in BUSY SHALL be dropped (no write, no extra ack) and ERR_COUNT incremented.
REQ-016 WR_COUNT SHALL increment on each accepted write to any decoded offset, wrapping 0xFFFF_FFFF->0.
REQ-017 ERR_COUNT SHALL saturate at 0xFFFF_FFFF.
REQ-018 Each accepted write to CTRL with data bit1=1 SHALL clear WR_COUNT and ERR_COUNT; bit1 is self-clearing and reads 0.

Reset
REQ-019 On ctrlport_rst_n low: FSM IDLE, resp_ack=0, resp_data=0, SCRATCH=0, GAIN=16'h0100 (unity Q8.8), CTRL=0, enable=0, counters=0.
REQ-020 Reset asserted in BUSY SHALL abort the pending response; no ack after release.
REQ-021 Deassertion SHALL be synchronised internally; first request accepted on the second edge after release.

Configuration
REQ-022 Macro CTRLPORT_GAIN_REGS_ERR_CNT_EN: defined -> ERR_COUNT implemented per REQ-014/015/017; undefined -> no counter logic, offset 0x14 reads 0, REQ-014/015 behaviour otherwise unchanged.

Verification
REQ-023 After reset, read 0x00, 0x08, 0x0C -> 0x0001_0000, 0x0000_0100, 0x0 with ack at cycle+1 (RESP_LATENCY=1).
REQ-024 Write 0x04=0xDEAD_BEEF, read back -> 0xDEAD_BEEF; WR_COUNT reads 1.
REQ-025 RESP_LATENCY=3: write 0x08=0x1234_0200 -> gain=0x0200 next cycle, ack at cycle+3; read 0x08 -> 0x0000_0200.
REQ-026 Request during BUSY (RESP_LATENCY=4) and simultaneous wr+rd -> one ack each, ERR_COUNT=2 (macro defined) / 0 (undefined).
REQ-027 Request at BASE_ADDR+0x20 -> no ack for 8 cycles; reset pulse mid-BUSY -> no ack, all registers at reset values.
REQ-028 Write CTRL=0x3 -> enable=1, counters read 0, CTRL reads 0x1.

Source files
------------

// File: rtl/ctrlport_gain_regs.sv
// rtl/ctrlport_gain_regs.sv - control-port register block for a gain/enable stage
//
// Registers at BASE_ADDR (32-byte window, word offsets addr[4:2]):
//   0x00 COMPAT RO, 0x04 SCRATCH RW, 0x08 GAIN RW[15:0], 0x0C CTRL RW[0]
//   (bit1 write = clear counters, self-clearing), 0x10 WR_COUNT RO,
//   0x14 ERR_COUNT RO, 0x18/0x1C reserved (read 0).
// Optional feature: define CTRLPORT_GAIN_REGS_ERR_CNT_EN to implement ERR_COUNT;
// otherwise offset 0x14 reads 0 and no counter logic exists.
//
// Ports:
//   ctrlport_clk, ctrlport_rst_n   clock, async active-low reset
//   s_ctrlport_req_wr/_rd          one-cycle write/read strobes
//   s_ctrlport_req_addr[19:0]      byte address
//   s_ctrlport_req_data[31:0]      write data
//   s_ctrlport_resp_ack            one-cycle response, RESP_LATENCY after request
//   s_ctrlport_resp_data[31:0]     read data, zero when ack is low
//   gain[15:0], enable             live GAIN register and CTRL[0]

`timescale 1ns/1ps

module ctrlport_gain_regs #(
  parameter logic [19:0] BASE_ADDR    = 20'h0,
  parameter int          RESP_LATENCY = 1,
  parameter logic [31:0] COMPAT_NUM   = 32'h0001_0000
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst_n,
  input  logic        s_ctrlport_req_wr,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  input  logic [31:0] s_ctrlport_req_data,
  output logic        s_ctrlport_resp_ack,
  output logic [31:0] s_ctrlport_resp_data,
  output logic [15:0] gain,
  output logic        enable
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] LAT_M1 = 2'(RESP_LATENCY - 1);

  localparam logic [2:0] OFF_COMPAT  = 3'd0;
  localparam logic [2:0] OFF_SCRATCH = 3'd1;
  localparam logic [2:0] OFF_GAIN    = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_WRCNT   = 3'd4;
  localparam logic [2:0] OFF_ERRCNT  = 3'd5;

  logic [0:0]  state;
  logic [1:0]  lat_cnt;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic [31:0] scratch;
  logic [15:0] gain_q;
  logic        ctrl_en;
  logic [31:0] wr_count;
  logic [31:0] err_rd;

  // Reset release is asynchronous to the clock, so requests are held off
  // until this flag has been clocked high once: the first request is taken
  // on the second edge after release.
  logic        req_ready;

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= 1'b1;
    end
  end

  // Byte lanes are not decoded; only whole 32-bit registers exist.
  logic addr_unused;
  assign addr_unused = ^s_ctrlport_req_addr[1:0];

  logic [2:0] offset;
  logic       hit;
  logic       any_req;
  logic       accept;
  logic       do_write;
  logic       ctrl_clr;

  assign offset   = s_ctrlport_req_addr[4:2];
  assign hit      = (s_ctrlport_req_addr[19:5] == BASE_ADDR[19:5]);
  assign any_req  = (s_ctrlport_req_wr | s_ctrlport_req_rd) & hit & req_ready;
  assign accept   = any_req & (state == ST_IDLE);
  assign do_write = accept & s_ctrlport_req_wr;
  assign ctrl_clr = do_write & (offset == OFF_CTRL) & s_ctrlport_req_data[1];

  // Read mux sees the pre-write register values, which is what a combined
  // write+read returns.
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'h0;
    case (offset)
      OFF_COMPAT:  rd_mux = COMPAT_NUM;
      OFF_SCRATCH: rd_mux = scratch;
      OFF_GAIN:    rd_mux = {16'h0, gain_q};
      OFF_CTRL:    rd_mux = {31'h0, ctrl_en};
      OFF_WRCNT:   rd_mux = wr_count;
      OFF_ERRCNT:  rd_mux = err_rd;
      default:     rd_mux = 32'h0;
    endcase
  end

  // Response sequencing: BUSY covers every cycle up to and including the
  // ack cycle, so a request landing on the ack cycle is also dropped.
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= 2'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_BUSY;
            lat_cnt <= LAT_M1;
            ack_q   <= (LAT_M1 == 2'd0);
            rdata_q <= s_ctrlport_req_rd ? rd_mux : 32'h0;
          end
        end
        ST_BUSY: begin
          if (ack_q) begin
            state   <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
            if (lat_cnt == 2'd1) begin
              ack_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ctrlport_resp_ack  = ack_q;
  assign s_ctrlport_resp_data = rdata_q & {32{ack_q}};

  // Writes land on the accepting edge regardless of response latency.
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      scratch <= 32'h0;
      gain_q  <= 16'h0100;
      ctrl_en <= 1'b0;
    end else if (do_write) begin
      case (offset)
        OFF_SCRATCH: scratch <= s_ctrlport_req_data;
        OFF_GAIN:    gain_q  <= s_ctrlport_req_data[15:0];
        OFF_CTRL:    ctrl_en <= s_ctrlport_req_data[0];
        default:     ;
      endcase
    end
  end

  // Counter clear from CTRL bit1 wins over the increment of the same write.
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      wr_count <= 32'h0;
    end else if (ctrl_clr) begin
      wr_count <= 32'h0;
    end else if (do_write) begin
      wr_count <= wr_count + 32'd1;
    end
  end

`ifdef CTRLPORT_GAIN_REGS_ERR_CNT_EN
  logic [31:0] err_count;
  logic        err_evt;

  // A dropped request while busy and a combined write+read are both errors.
  assign err_evt = (any_req & (state == ST_BUSY)) |
                   (accept & s_ctrlport_req_wr & s_ctrlport_req_rd);

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      err_count <= 32'h0;
    end else if (ctrl_clr) begin
      err_count <= 32'h0;
    end else if (err_evt && (err_count != 32'hFFFF_FFFF)) begin
      err_count <= err_count + 32'd1;
    end
  end

  assign err_rd = err_count;
`else
  assign err_rd = 32'h0;
`endif

  assign gain   = gain_q;
  assign enable = ctrl_en;

endmodule
